// File: rtl/stream_demux_pkg.sv
// ---------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the stream_demux1to2 packet demultiplexer.
//   state_e     : routing FSM states (IDLE, ROUTE_A, ROUTE_B)
//   PORT_A/B    : destination index values, matching the encoding of `sel`
//   COUNT_W     : width of the optional per-port packet counters
//   sat_inc16() : saturating increment used by the packet counters
// ---------------------------------------------------------------------------
package stream_demux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int COUNT_W = 16;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc16(input logic [COUNT_W-1:0] v);
    logic [COUNT_W-1:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage : stream_demux_pkg

// File: rtl/stream_demux1to2_slot.sv
// ---------------------------------------------------------------------------
// stream_slot
// One-entry registered skid-free output slot with valid/ready on both sides.
// A beat written in cycle N is visible on the output in cycle N+1. When the
// slot is full and drains in the same cycle it is refilled, the slot stays
// valid and takes the new beat, so it sustains one beat per cycle.
//
// Parameters:
//   WIDTH      payload width (the demux stores {last, data} here)
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; empties the slot, zeroes data
//   in_valid   write request
//   in_ready   slot can take a beat this cycle (empty, or draining now)
//   in_data    payload to store
//   out_valid  slot holds a beat
//   out_ready  downstream consumes the held beat this cycle
//   out_data   stored payload, stable while out_valid && !out_ready
// ---------------------------------------------------------------------------
module stream_slot #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next-state of the slot: fill wins over drain so a simultaneous
  // drain+fill keeps the slot valid with the fresh beat.
  always_comb begin
    in_ready = (!valid_q) || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_valid && in_ready) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule : stream_slot

// File: rtl/stream_demux1to2.sv
// ---------------------------------------------------------------------------
// stream_demux1to2
// Routes whole packets from one valid/ready input stream to one of two
// output streams. The destination is taken from `sel` on the accepted first
// beat of a packet and held until the accepted beat carrying in_last.
// Each output owns a one-entry registered slot (latency 1, full throughput).
//
// Build option:
//   STREAM_DEMUX_COUNT_EN  adds a_count/b_count (16-bit, saturating) counting
//                          packets leaving each port (beats with last=1).
//
// Parameters:
//   WIDTH          payload width (default 8)
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   in_valid/in_ready/in_data/in_last  upstream stream
//   sel            destination on the first beat (0 -> a, 1 -> b)
//   a_valid/a_ready/a_data/a_last      port a stream
//   b_valid/b_ready/b_data/b_last      port b stream
//   a_count/b_count (optional)         completed packets per port
// ---------------------------------------------------------------------------
module stream_demux1to2
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_last,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_last
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [15:0]      a_count,
  output logic [15:0]      b_count
`endif
);

  state_e state_q;
  state_e state_d;

  logic           dest_s;
  logic           fire_s;
  logic           a_fill_s;
  logic           b_fill_s;
  logic           a_slot_ready_s;
  logic           b_slot_ready_s;
  logic [WIDTH:0] in_payload_s;
  logic [WIDTH:0] a_payload_s;
  logic [WIDTH:0] b_payload_s;

  // Destination: sel only matters in IDLE; inside a packet the state decides.
  always_comb begin
    dest_s = PORT_A;
    case (state_q)
      IDLE:    dest_s = sel;
      ROUTE_A: dest_s = PORT_A;
      ROUTE_B: dest_s = PORT_B;
      default: dest_s = PORT_A;
    endcase
  end

  // Upstream handshake and slot write strobes. in_ready looks only at the
  // destination slot, so a full non-destination slot never stalls input.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else if (dest_s == PORT_B) begin
      in_ready = b_slot_ready_s;
    end else begin
      in_ready = a_slot_ready_s;
    end
    fire_s   = in_valid && in_ready;
    a_fill_s = fire_s && (dest_s == PORT_A);
    b_fill_s = fire_s && (dest_s == PORT_B);
  end

  // FSM next state. A single-beat packet (last on the first beat) leaves the
  // FSM in IDLE.
  always_comb begin
    state_d = state_q;
    if (fire_s) begin
      case (state_q)
        IDLE: begin
          if (in_last) begin
            state_d = IDLE;
          end else if (sel == PORT_B) begin
            state_d = ROUTE_B;
          end else begin
            state_d = ROUTE_A;
          end
        end
        ROUTE_A, ROUTE_B: begin
          if (in_last) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state register; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_payload_s = {in_last, in_data};

  stream_slot #(
    .WIDTH (WIDTH + 1)
  ) u_slot_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_fill_s),
    .in_ready  (a_slot_ready_s),
    .in_data   (in_payload_s),
    .out_valid (a_valid),
    .out_ready (a_ready),
    .out_data  (a_payload_s)
  );

  stream_slot #(
    .WIDTH (WIDTH + 1)
  ) u_slot_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_fill_s),
    .in_ready  (b_slot_ready_s),
    .in_data   (in_payload_s),
    .out_valid (b_valid),
    .out_ready (b_ready),
    .out_data  (b_payload_s)
  );

  assign a_last = a_payload_s[WIDTH];
  assign a_data = a_payload_s[WIDTH-1:0];
  assign b_last = b_payload_s[WIDTH];
  assign b_data = b_payload_s[WIDTH-1:0];

`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0] a_count_q;
  logic [15:0] a_count_d;
  logic [15:0] b_count_q;
  logic [15:0] b_count_d;

  // A packet is complete when its last beat leaves the slot.
  always_comb begin
    a_count_d = a_count_q;
    b_count_d = b_count_q;
    if (a_valid && a_ready && a_last) begin
      a_count_d = sat_inc16(a_count_q);
    end else begin
      a_count_d = a_count_q;
    end
    if (b_valid && b_ready && b_last) begin
      b_count_d = sat_inc16(b_count_q);
    end else begin
      b_count_d = b_count_q;
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_count_q <= 16'd0;
      b_count_q <= 16'd0;
    end else begin
      a_count_q <= a_count_d;
      b_count_q <= b_count_d;
    end
  end

  assign a_count = a_count_q;
  assign b_count = b_count_q;
`endif

endmodule : stream_demux1to2

// File: tb/tb_stream_demux1to2.sv
// ---------------------------------------------------------------------------
// tb_stream_demux1to2
// Directed self-checking bench for stream_demux1to2 (WIDTH=8). Inputs change
// 1 time unit after a rising edge; registered outputs are checked at that
// point and in_ready is checked 1 time unit after the inputs settle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_demux1to2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       sel;
  logic       a_valid;
  logic       a_ready;
  logic [7:0] a_data;
  logic       a_last;
  logic       b_valid;
  logic       b_ready;
  logic [7:0] b_data;
  logic       b_last;
`ifdef STREAM_DEMUX_COUNT_EN
  logic [15:0] a_count;
  logic [15:0] b_count;
`endif

  int total;
  int bad;

  stream_demux1to2 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .sel      (sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .a_last   (a_last),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .b_last   (b_last)
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    .a_count  (a_count),
    .b_count  (b_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one upstream beat (or idle) and let combinational logic settle.
  task automatic drive(input logic v, input logic [7:0] d, input logic s, input logic l);
    in_valid = v;
    in_data  = d;
    sel      = s;
    in_last  = l;
    #1;
  endtask

  task automatic test_reset();
    a_ready = 1'b1;
    b_ready = 1'b1;
    rst = 1'b1;
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_in_ready cycle %0d: got %b want 0", i, in_ready);
      end
      tick();
    end
    total++;
    if ({a_valid, b_valid, a_data, b_data, a_last, b_last} !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs: got av=%b bv=%b ad=%h bd=%h al=%b bl=%b want all 0",
               a_valid, b_valid, a_data, b_data, a_last, b_last);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_single_beat();
    b_ready = 1'b1;
    drive(1'b1, 8'h3C, 1'b1, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_in_ready: got %b want 1", in_ready);
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if ({b_valid, b_data, b_last, a_valid} !== {1'b1, 8'h3C, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_out: got bv=%b bd=%h bl=%b av=%b want bv=1 bd=3c bl=1 av=0",
               b_valid, b_data, b_last, a_valid);
    end
    tick();
    total++;
    if (b_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: got b_valid=%b want 0", b_valid);
    end
  endtask

  task automatic test_sticky();
    logic [7:0] dat [3];
    logic       sl  [3];
    logic       lst [3];
    dat[0] = 8'h11; sl[0] = 1'b0; lst[0] = 1'b0;
    dat[1] = 8'h22; sl[1] = 1'b1; lst[1] = 1'b0;
    dat[2] = 8'h33; sl[2] = 1'b1; lst[2] = 1'b1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, dat[i], sl[i], lst[i]);
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL sticky_in_ready beat %0d: got %b want 1", i, in_ready);
      end
      tick();
      total++;
      if ({a_valid, a_data, a_last, b_valid} !== {1'b1, dat[i], lst[i], 1'b0}) begin
        bad++;
        $display("FAIL sticky_beat%0d: got av=%b ad=%h al=%b bv=%b want av=1 ad=%h al=%b bv=0",
                 i, a_valid, a_data, a_last, b_valid, dat[i], lst[i]);
      end
    end
    // Back in IDLE: sel=1 now steers a new single-beat packet to b.
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if ({b_valid, b_data, a_valid} !== {1'b1, 8'h5A, 1'b0}) begin
      bad++;
      $display("FAIL sticky_next_pkt: got bv=%b bd=%h av=%b want bv=1 bd=5a av=0",
               b_valid, b_data, a_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    a_ready = 1'b0;
    b_ready = 1'b1;
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({in_ready, a_valid, a_data, a_last} !== {1'b0, 1'b1, 8'h44, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold cycle %0d: got ir=%b av=%b ad=%h al=%b want ir=0 av=1 ad=44 al=0",
                 i, in_ready, a_valid, a_data, a_last);
      end
      tick();
    end
    a_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release_ready: got %b want 1", in_ready);
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if ({a_valid, a_data, a_last} !== {1'b1, 8'h55, 1'b1}) begin
      bad++;
      $display("FAIL bp_second: got av=%b ad=%h al=%b want av=1 ad=55 al=1",
               a_valid, a_data, a_last);
    end
    tick();
    total++;
    if (a_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_drain: got a_valid=%b want 0", a_valid);
    end
  endtask

  task automatic test_independence();
    a_ready = 1'b1;
    b_ready = 1'b0;
    drive(1'b1, 8'h66, 1'b1, 1'b1);
    tick();
    // b is full and stalled: a packet for b must wait.
    drive(1'b1, 8'h70, 1'b1, 1'b1);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL indep_b_blocked: got in_ready=%b want 0", in_ready);
    end
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL indep_a_ready: got in_ready=%b want 1", in_ready);
    end
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if ({a_valid, a_data, b_valid, b_data, b_last} !== {1'b1, 8'h77, 1'b1, 8'h66, 1'b1}) begin
      bad++;
      $display("FAIL indep_out: got av=%b ad=%h bv=%b bd=%h bl=%b want av=1 ad=77 bv=1 bd=66 bl=1",
               a_valid, a_data, b_valid, b_data, b_last);
    end
    b_ready = 1'b1;
    tick();
    total++;
    if ({a_valid, b_valid} !== 2'b00) begin
      bad++;
      $display("FAIL indep_drain: got av=%b bv=%b want 0 0", a_valid, b_valid);
    end
  endtask

  task automatic test_mid_reset();
    a_ready = 1'b1;
    b_ready = 1'b0;
    drive(1'b1, 8'h88, 1'b1, 1'b0);
    tick();
    total++;
    if ({b_valid, b_data} !== {1'b1, 8'h88}) begin
      bad++;
      $display("FAIL midrst_beat1: got bv=%b bd=%h want bv=1 bd=88", b_valid, b_data);
    end
    rst = 1'b1;
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_in_ready: got %b want 0", in_ready);
    end
    tick();
    rst = 1'b0;
    total++;
    if ({b_valid, b_data} !== {1'b0, 8'h00}) begin
      bad++;
      $display("FAIL midrst_cleared: got bv=%b bd=%h want bv=0 bd=00", b_valid, b_data);
    end
    b_ready = 1'b1;
    drive(1'b1, 8'hC3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if ({a_valid, a_data, a_last, b_valid} !== {1'b1, 8'hC3, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_next_to_a: got av=%b ad=%h al=%b bv=%b want av=1 ad=c3 al=1 bv=0",
               a_valid, a_data, a_last, b_valid);
    end
    tick();
`ifdef STREAM_DEMUX_COUNT_EN
    total++;
    if ({a_count, b_count} !== {16'd1, 16'd0}) begin
      bad++;
      $display("FAIL midrst_counts: got a=%0d b=%0d want a=1 b=0", a_count, b_count);
    end
`endif
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    sel      = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    tick();
    test_reset();
    test_single_beat();
    test_sticky();
    test_backpressure();
    test_independence();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_demux1to2

// File: doc/stream_demux1to2.md
STREAM_DEMUX1TO2 -- requirements
Module: stream_demux1to2

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning payload bit width.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  upstream beat valid.
REQ-005 SHALL have port in_ready  output  1  upstream beat accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-007 SHALL have port in_last  input  1  final beat of packet.
REQ-008 SHALL have port sel  input  1  destination (0 -> port a, 1 -> port b), meaningful on first beat of packet only.
REQ-009 SHALL have ports a_valid/b_valid  output  1, a_ready/b_ready  input  1, a_data/b_data  output  WIDTH, a_last/b_last  output  1.

Function
REQ-010 SHALL route whole packets: sel sampled on the accepted first beat, held until the accepted beat with in_last=1.
REQ-011 SHALL implement FSM states IDLE, ROUTE_A, ROUTE_B.
REQ-012 IDLE: accepted beat with sel=0 -> ROUTE_A, sel=1 -> ROUTE_B; if that beat has in_last=1, stay IDLE (single-beat packet).
REQ-013 ROUTE_A/ROUTE_B: accepted beat with in_last=1 -> IDLE; sel ignored.
REQ-014 Each output port SHALL own a one-entry registered slot; accepted beat appears on port output the cycle after acceptance (latency 1).
REQ-015 in_ready SHALL be 1 iff destination slot (from sel in IDLE, from state otherwise) is empty or its ready is high this cycle; combinational from slot state, target ready and sel only.
REQ-016 Slot simultaneous drain and fill SHALL keep valid=1 and load new beat (full throughput, one beat/cycle per port).
REQ-017 Non-destination port SHALL keep its slot contents and drain independently; head-of-line blocking on full destination is acceptable.
REQ-018 x_data/x_last SHALL be stable while x_valid=1 and x_ready=0.
REQ-019 No beat SHALL be dropped, duplicated or reordered within a port.

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE and clear both slots: a_valid=b_valid=0, a_data=b_data=0, a_last=b_last=0.
REQ-021 During rst=1, in_ready SHALL be 0; reset mid-packet discards the partial packet and buffered beats.

Configuration
REQ-022 Macro STREAM_DEMUX_COUNT_EN, when defined, SHALL add outputs a_count, b_count (output, 16 bits) counting completed packets (accepted out-of-slot beats with last=1) per port, saturating at 16'hFFFF, cleared by rst.
REQ-023 Without STREAM_DEMUX_COUNT_EN the counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-024 Shared package stream_demux_pkg SHALL hold the FSM state typedef (IDLE, ROUTE_A, ROUTE_B) and port-index constants PORT_A=0, PORT_B=1.
REQ-025 The one-entry output register SHALL be sub-module stream_slot (WIDTH+1 bit payload, valid/ready both sides), instantiated twice.

Verification
REQ-026 Reset: assert rst 2 cycles with in_valid=1 -> in_ready=0, a_valid=b_valid=0, state IDLE after release.
REQ-027 Single-beat: in_data=8'h3C, sel=1, in_last=1, b_ready=1 -> next cycle b_valid=1, b_data=8'h3C, b_last=1, a_valid=0.
REQ-028 Sticky routing: 3-beat packet 8'h11,8'h22,8'h33 with sel=0,1,1 and last on third -> all three on port a in order, last only with 8'h33, port b silent.
REQ-029 Backpressure: a_ready=0 during 2-beat packet to a -> first beat held stable on a_data, in_ready=0 for second beat until a_ready=1, then 1 beat/cycle.
REQ-030 Independence: b slot full with b_ready=0, new packet sel=0 -> accepted and delivered on a while b_data unchanged.
REQ-031 Mid-packet reset: rst after beat 1 of 3-beat packet to b -> b_valid=0 next cycle; next packet with sel=0 goes to a; with STREAM_DEMUX_COUNT_EN, b_count=0.
